// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Programmable integer clock divider. Produces a registered
//                divided clock for any ratio >= 2 (odd ratios spend the
//                extra cycle low), one-cycle rise/fall strobes in the
//                CLK_IN domain, and glitch-free runtime ratio changes that
//                take effect only at a period boundary.
//  Revision    : 1.0 - initial release, successor to fixed divide-by-40
// ============================================================================
module clk_div_prog #(
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 40
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_VAL,
  input  logic             DIV_LOAD,
  output logic             DIV_BUSY,
  output logic             DIV_ERR,
  output logic             CLK_DIV,
  output logic             RISE_STB,
  output logic             FALL_STB
);

  // Divisor used at reset, truncated to the counter width.
  localparam logic [CNT_W-1:0] c_div_init = CNT_W'(DIV_INIT);
  // Unit constants at the two widths used below.
  localparam logic [CNT_W:0]   c_one_x    = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two      = CNT_W'(2);

  // The output level doubles as the phase state.
  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  // State registers and their next-state values.
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] div_q,   div_d;    // active divisor
  logic [CNT_W-1:0] pend_q,  pend_d;   // pending divisor
  logic             busy_q,  busy_d;
  logic             err_q,   err_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  // Phase lengths are computed one bit wider so D = 2^CNT_W-1 cannot wrap.
  logic [CNT_W:0]   div_x;
  logic [CNT_W:0]   cnt_x;
  logic [CNT_W:0]   low_len;
  logic [CNT_W:0]   high_len;
  logic             low_done;
  logic             high_done;
  logic             load_ok;
  logic             load_bad;
  logic             apply_pend;

  assign div_x     = {1'b0, div_q};
  assign cnt_x     = {1'b0, cnt_q};
  assign low_len   = (div_x + c_one_x) >> 1;
  assign high_len  = div_x >> 1;
  assign low_done  = (cnt_x == (low_len  - c_one_x));
  assign high_done = (cnt_x == (high_len - c_one_x));

  // Ratios below 2 cannot be produced, so such requests are rejected.
  assign load_ok   = DIV_LOAD && (DIV_VAL >= c_two);
  assign load_bad  = DIV_LOAD && (DIV_VAL <  c_two);

  // Phase sequencing, strobe generation and divisor hand-over.
  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    err_d      = err_q | load_bad;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    apply_pend = 1'b0;

    if (!EN) begin
      // Idle: park low; a falling edge is still reported if we were high.
      phase_d    = PH_LOW;
      cnt_d      = '0;
      fall_d     = (phase_q == PH_HIGH);
      apply_pend = 1'b1;
    end else if (phase_q == PH_LOW) begin
      if (low_done) begin
        phase_d = PH_HIGH;
        cnt_d   = '0;
        rise_d  = 1'b1;
      end else begin
        cnt_d   = cnt_q + c_one;
      end
    end else begin
      if (high_done) begin
        // HIGH->LOW is the period boundary where a new divisor may start.
        phase_d    = PH_LOW;
        cnt_d      = '0;
        fall_d     = 1'b1;
        apply_pend = 1'b1;
      end else begin
        cnt_d      = cnt_q + c_one;
      end
    end

    // The boundary consumes the value that was already pending.
    if (apply_pend && busy_q) begin
      div_d  = pend_q;
      busy_d = 1'b0;
    end

    // A request arriving on the same edge waits for the next boundary.
    if (load_ok) begin
      pend_d = DIV_VAL;
      busy_d = 1'b1;
    end
  end

  // State register with synchronous reset to the legacy divisor.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      phase_q <= PH_LOW;
      cnt_q   <= '0;
      div_q   <= c_div_init;
      pend_q  <= c_div_init;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign CLK_DIV  = phase_q;
  assign RISE_STB = rise_q;
  assign FALL_STB = fall_q;
  assign DIV_BUSY = busy_q;
  assign DIV_ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_prog
//  Description : Self-checking bench for clk_div_prog: table of divisors
//                with expected low/high phase lengths, plus directed
//                sequences for reset timing, invalid loads, back-to-back
//                loads, load on the boundary, enable drop and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             busy;
  logic             err;
  logic             clk_div;
  logic             rise;
  logic             fall;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [CNT_W-1:0] div;
    int               lo;
    int               hi;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  clk_div_prog #(
    .CNT_W    (CNT_W),
    .DIV_INIT (40)
  ) dut (
    .CLK_IN   (clk),
    .RST      (rst),
    .EN       (en),
    .DIV_VAL  (div_val),
    .DIV_LOAD (div_load),
    .DIV_BUSY (busy),
    .DIV_ERR  (err),
    .CLK_DIV  (clk_div),
    .RISE_STB (rise),
    .FALL_STB (fall)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for the pending divisor to be applied; must land on a falling edge.
  task automatic wait_busy_clear();
    int n = 0;
    while (busy && n < 300) begin
      step(1);
      n++;
    end
    check("busy_clear_in_time", int'(n < 300), 1);
    check("apply_on_fall_clk", int'(clk_div), 0);
    check("apply_on_fall_stb", int'(fall), 1);
  endtask

  // Advance until a falling strobe is seen.
  task automatic sync_fall();
    int n = 0;
    while (!fall && n < 300) begin
      step(1);
      n++;
    end
    check("sync_fall_in_time", int'(n < 300), 1);
  endtask

  // Starting on the cycle a fall strobe is visible, measure one low and one
  // high phase and verify strobe placement; ends on the next fall cycle.
  task automatic measure(output int lo, output int hi);
    int bad = 0;
    lo = 0;
    hi = 0;
    while (clk_div == 1'b0 && lo < 1000) begin
      if (rise != 1'b0 || fall != (lo == 0)) bad++;
      lo++;
      step(1);
    end
    while (clk_div == 1'b1 && hi < 1000) begin
      if (rise != (hi == 0) || fall != 1'b0) bad++;
      hi++;
      step(1);
    end
    check("fall_stb_at_period_end", int'(fall), 1);
    check("strobe_shape", bad, 0);
  endtask

  task automatic load(input int v);
    div_load = 1'b1;
    div_val  = CNT_W'(v);
    step(1);
    div_load = 1'b0;
  endtask

  initial begin
    int lo;
    int hi;

    vecs[0] = '{div: 16'd5,  lo: 3,  hi: 2};
    vecs[1] = '{div: 16'd2,  lo: 1,  hi: 1};
    vecs[2] = '{div: 16'd3,  lo: 2,  hi: 1};
    vecs[3] = '{div: 16'd8,  lo: 4,  hi: 4};
    vecs[4] = '{div: 16'd9,  lo: 5,  hi: 4};
    vecs[5] = '{div: 16'd40, lo: 20, hi: 20};

    rst      = 1'b1;
    en       = 1'b1;
    div_val  = '0;
    div_load = 1'b0;

    // Reset default: last reset edge is edge 0.
    step(3);
    check("rst_clk_div", int'(clk_div), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    step(19);
    check("edge19_low", int'(clk_div), 0);
    step(1);
    check("edge20_rise_clk", int'(clk_div), 1);
    check("edge20_rise_stb", int'(rise), 1);
    step(1);
    check("edge21_rise_stb_off", int'(rise), 0);
    step(18);
    check("edge39_high", int'(clk_div), 1);
    step(1);
    check("edge40_fall_clk", int'(clk_div), 0);
    check("edge40_fall_stb", int'(fall), 1);
    measure(lo, hi);
    check("default_lo", lo, 20);
    check("default_hi", hi, 20);

    // Back-to-back loads mid-period: only the last one is used.
    step(5);
    load(7);
    check("b2b_busy_after_first", int'(busy), 1);
    load(9);
    check("b2b_busy_after_second", int'(busy), 1);
    wait_busy_clear();
    measure(lo, hi);
    check("b2b_lo", lo, 5);
    check("b2b_hi", hi, 4);
    measure(lo, hi);
    check("b2b_lo_repeat", lo, 5);
    check("b2b_hi_repeat", hi, 4);

    // Table of divisors and expected phase lengths.
    for (int i = 0; i < 6; i++) begin
      load(int'(vecs[i].div));
      check($sformatf("tbl%0d_busy", i), int'(busy), 1);
      wait_busy_clear();
      measure(lo, hi);
      check($sformatf("tbl%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("tbl%0d_hi", i), hi, vecs[i].hi);
    end

    // Minimum ratio, then invalid loads are ignored and flagged.
    load(2);
    wait_busy_clear();
    check("err_before_invalid", int'(err), 0);
    load(1);
    check("inv1_busy", int'(busy), 0);
    check("inv1_err", int'(err), 1);
    load(0);
    check("inv0_busy", int'(busy), 0);
    check("inv0_err", int'(err), 1);
    sync_fall();
    measure(lo, hi);
    check("min_lo", lo, 1);
    check("min_hi", hi, 1);

    // Load on the boundary cycle with D=4.
    load(4);
    wait_busy_clear();
    step(3);
    check("bnd_in_high", int'(clk_div), 1);
    load(6);
    check("bnd_fall_now", int'(fall), 1);
    check("bnd_still_busy", int'(busy), 1);
    measure(lo, hi);
    check("bnd_old_lo", lo, 2);
    check("bnd_old_hi", hi, 2);
    check("bnd_busy_cleared", int'(busy), 0);
    measure(lo, hi);
    check("bnd_new_lo", lo, 3);
    check("bnd_new_hi", hi, 3);

    // Enable drop mid-high (D=6: rise 3 edges after the fall).
    step(4);
    check("en_mid_high", int'(clk_div), 1);
    en = 1'b0;
    step(1);
    check("en_drop_clk", int'(clk_div), 0);
    check("en_drop_fall", int'(fall), 1);
    step(3);
    check("en_hold_clk", int'(clk_div), 0);
    check("en_hold_fall", int'(fall), 0);
    check("en_hold_rise", int'(rise), 0);
    load(10);
    check("idle_load_busy", int'(busy), 1);
    step(1);
    check("idle_load_applied", int'(busy), 0);
    en = 1'b1;
    step(4);
    check("en_up_still_low", int'(clk_div), 0);
    step(1);
    check("en_up_rise_clk", int'(clk_div), 1);
    check("en_up_rise_stb", int'(rise), 1);
    step(5);
    check("d10_fall_clk", int'(clk_div), 0);
    check("d10_fall_stb", int'(fall), 1);
    check("err_sticky", int'(err), 1);

    // Reset mid-high with a concurrent load request.
    step(5);
    check("d10_rise_again", int'(clk_div), 1);
    step(1);
    rst      = 1'b1;
    div_load = 1'b1;
    div_val  = 16'd7;
    step(1);
    rst      = 1'b0;
    div_load = 1'b0;
    check("rst2_clk_div", int'(clk_div), 0);
    check("rst2_rise", int'(rise), 0);
    check("rst2_fall", int'(fall), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_err", int'(err), 0);
    step(19);
    check("rst2_edge19_low", int'(clk_div), 0);
    step(1);
    check("rst2_edge20_rise", int'(rise), 1);
    step(20);
    check("rst2_edge40_fall", int'(fall), 1);
    check("rst2_no_pending", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
